// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one UART transmitter between NUM_REQ byte sources.
// Optional stalled-lock breaking is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int SYS_PERIOD   = 100_000_000,
  parameter int BPS          = 115_200,
  parameter int FRAME_CYCLES = (SYS_PERIOD / BPS) * 10,
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       locked,
  output logic                       busy,
  output logic                       lock_timeout
);

  localparam int IDW   = $clog2(NUM_REQ);
  localparam int IDW1  = IDW + 1;
  localparam int CNT_W = $clog2(FRAME_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [IDW1-1:0]  NUM_REQ_W = IDW1'(NUM_REQ);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [IDW-1:0]     owner_q, owner_d;
  logic               locked_q, locked_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [IDW-1:0]     grant_q, grant_d;

  logic [NUM_REQ-1:0] eligible;
  logic [IDW-1:0]     idx;
  logic [IDW-1:0]     winner;
  logic               found;
  logic               hs;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            lock_timeout_q, lock_timeout_d;
`endif

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input logic [IDW1-1:0] off);
    logic [IDW1-1:0] sum;
    sum = {1'b0, base} + off;
    if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
    return sum[IDW-1:0];
  endfunction

  // A held lock narrows the candidates to the packet owner; scan starts at ptr.
  always_comb begin
    eligible = locked_q ? (req_valid & (NUM_REQ'(1) << owner_q)) : req_valid;
    found    = 1'b0;
    winner   = '0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = wrap_add(ptr_q, IDW1'(k));
      if (!found && eligible[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    hs        = (state_q == IDLE) && found && !rst;
    req_ready = hs ? (NUM_REQ'(1) << winner) : '0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    locked_d   = locked_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    grant_d    = grant_q;
`ifdef UART_ARB_TIMEOUT_EN
    to_cnt_d       = to_cnt_q;
    lock_timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (hs) begin
          tx_start_d = 1'b1;
          tx_data_d  = req_data[{winner, 3'b000} +: 8];
          grant_d    = winner;
          cnt_d      = CNT_LOAD;
          state_d    = WAIT;
          if (req_last[winner]) begin
            locked_d = 1'b0;
            ptr_d    = wrap_add(winner, IDW1'(1));
          end else begin
            locked_d = 1'b1;
            owner_d  = winner;
          end
`ifdef UART_ARB_TIMEOUT_EN
          to_cnt_d = '0;
        end else if (locked_q) begin
          // Owner has gone quiet mid-packet; release it after LOCK_TIMEOUT idle cycles.
          if (to_cnt_q == TO_LAST) begin
            locked_d       = 1'b0;
            ptr_d          = wrap_add(owner_q, IDW1'(1));
            lock_timeout_d = 1'b1;
            to_cnt_d       = '0;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
`endif
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      owner_q    <= '0;
      locked_q   <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      grant_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      locked_q   <= locked_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      grant_q    <= grant_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q       <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      to_cnt_q       <= to_cnt_d;
      lock_timeout_q <= lock_timeout_d;
    end
  end
  assign lock_timeout = lock_timeout_q;
`else
  assign lock_timeout = 1'b0;
`endif

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign grant_id = grant_q;
  assign locked   = locked_q;
  assign busy     = (state_q == WAIT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (FRAME_CYCLES=100, NUM_REQ=4, LOCK_TIMEOUT=20).
// The lock-timeout scenario runs when UART_ARB_TIMEOUT_EN is defined; otherwise the indefinite lock is checked.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [1:0]  grant_id;
  logic        locked;
  logic        busy;
  logic        lock_timeout;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_start  = 0;

  uart_tx_arbiter #(
    .SYS_PERIOD  (1000),
    .BPS         (100),
    .NUM_REQ     (4),
    .LOCK_TIMEOUT(20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant_id    (grant_id),
    .locked      (locked),
    .busy        (busy),
    .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int src, input logic v, input logic [7:0] d, input logic l);
    req_valid[src]       = v;
    req_data[src*8 +: 8] = d;
    req_last[src]        = l;
  endtask

  // Check the combinational grant now, then the registered results one cycle after the handshake.
  task automatic expectGrant(input string tag, input logic [3:0] exp_ready, input int src,
                             input logic [7:0] exp_data, input logic exp_locked, input int exp_gap);
    #1;
    checkOutput({tag, "_ready"}, req_ready, exp_ready);
    @(negedge clk);
    #1;
    checkOutput({tag, "_tx_start"}, tx_start, 1);
    checkOutput({tag, "_tx_data"}, tx_data, exp_data);
    checkOutput({tag, "_grant_id"}, grant_id, src);
    checkOutput({tag, "_locked"}, locked, exp_locked);
    checkOutput({tag, "_busy"}, busy, 1);
    if (exp_gap > 0) checkOutput({tag, "_gap"}, cyc - last_start, exp_gap);
    last_start = cyc;
  endtask

  // Count busy cycles until the arbiter is back in IDLE, bounded.
  task automatic waitFrame(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 300) begin
      n++;
      if (n == 2) checkOutput({tag, "_start_once"}, tx_start, 0);
      @(negedge clk);
      #1;
    end
    checkOutput({tag, "_busy_len"}, n, 100);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_tx_start"}, tx_start, 0);
    checkOutput({tag, "_tx_data"}, tx_data, 0);
    checkOutput({tag, "_grant_id"}, grant_id, 0);
    checkOutput({tag, "_locked"}, locked, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_lock_timeout"}, lock_timeout, 0);
    checkOutput({tag, "_ready"}, req_ready, 0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    #1;
    checkOutput("post_reset_ready", req_ready, 0);

    // Single byte from source 2 leaves ptr at 3.
    applyStimulus(2, 1'b1, 8'hA5, 1'b1);
    expectGrant("single", 4'b0100, 2, 8'hA5, 1'b0, 0);
    applyStimulus(2, 1'b0, 8'h00, 1'b0);
    waitFrame("single");

    // Wrap: with ptr=3, source 3 beats source 0, then ptr wraps to 0.
    applyStimulus(0, 1'b1, 8'h30, 1'b1);
    applyStimulus(3, 1'b1, 8'h33, 1'b1);
    expectGrant("wrap3", 4'b1000, 3, 8'h33, 1'b0, 101);
    applyStimulus(3, 1'b0, 8'h00, 1'b0);
    waitFrame("wrap3");
    expectGrant("wrap0", 4'b0001, 0, 8'h30, 1'b0, 101);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    waitFrame("wrap0");

    // Round-robin from a fresh reset: 0, 1, 3 all waiting.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 8'hC0, 1'b1);
    applyStimulus(1, 1'b1, 8'hC1, 1'b1);
    applyStimulus(3, 1'b1, 8'hC3, 1'b1);
    expectGrant("rr0", 4'b1011 & 4'b0001, 0, 8'hC0, 1'b0, 0);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    waitFrame("rr0");
    expectGrant("rr1", 4'b0010, 1, 8'hC1, 1'b0, 101);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    waitFrame("rr1");
    expectGrant("rr3", 4'b1000, 3, 8'hC3, 1'b0, 101);
    applyStimulus(3, 1'b0, 8'h00, 1'b0);
    waitFrame("rr3");

    // Packet lock: source 1's three bytes go before source 0 even though ptr is 0.
    applyStimulus(1, 1'b1, 8'h10, 1'b0);
    expectGrant("lock0", 4'b0010, 1, 8'h10, 1'b1, 0);
    applyStimulus(0, 1'b1, 8'h55, 1'b1);
    applyStimulus(1, 1'b1, 8'h11, 1'b0);
    waitFrame("lock0");
    expectGrant("lock1", 4'b0010, 1, 8'h11, 1'b1, 101);
    applyStimulus(1, 1'b1, 8'h12, 1'b1);
    waitFrame("lock1");
    expectGrant("lock2", 4'b0010, 1, 8'h12, 1'b0, 101);
    applyStimulus(1, 1'b0, 8'h00, 1'b0);
    waitFrame("lock2");
    expectGrant("lock_after", 4'b0001, 0, 8'h55, 1'b0, 101);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    waitFrame("lock_after");

    // Reset 50 cycles into a frame; waiting source 0 is taken right after release.
    applyStimulus(2, 1'b1, 8'h77, 1'b1);
    applyStimulus(0, 1'b1, 8'h5A, 1'b1);
    expectGrant("mid", 4'b0100, 2, 8'h77, 1'b0, 0);
    applyStimulus(2, 1'b0, 8'h00, 1'b0);
    repeat (50) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkResetOutputs("mid_rst");
    rst = 1'b0;
    expectGrant("post_rst", 4'b0001, 0, 8'h5A, 1'b0, 0);
    applyStimulus(0, 1'b0, 8'h00, 1'b0);
    waitFrame("post_rst");

    // Source 2 opens a packet then stalls while source 3 waits.
    applyStimulus(2, 1'b1, 8'h21, 1'b0);
    expectGrant("stall", 4'b0100, 2, 8'h21, 1'b1, 0);
    applyStimulus(2, 1'b0, 8'h00, 1'b0);
    applyStimulus(3, 1'b1, 8'h31, 1'b1);
    waitFrame("stall");
`ifdef UART_ARB_TIMEOUT_EN
    for (int k = 0; k < 20; k++) begin
      checkOutput("to_wait_pulse", lock_timeout, 0);
      checkOutput("to_wait_ready", req_ready, 0);
      @(negedge clk);
      #1;
    end
    checkOutput("to_pulse", lock_timeout, 1);
    checkOutput("to_unlocked", locked, 0);
    expectGrant("to_src3", 4'b1000, 3, 8'h31, 1'b0, 0);
    checkOutput("to_pulse_end", lock_timeout, 0);
    applyStimulus(3, 1'b0, 8'h00, 1'b0);
    waitFrame("to_src3");
`else
    for (int k = 0; k < 30; k++) begin
      checkOutput("hold_ready", req_ready, 0);
      @(negedge clk);
      #1;
    end
    checkOutput("hold_locked", locked, 1);
    checkOutput("hold_no_pulse", lock_timeout, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
